// File: rtl/binoc_pkg.sv
// Shared types and helpers for the BiNoC bidirectional channel direction controller.
package binoc_pkg;

  typedef enum logic [1:0] {
    OWN  = 2'd0,
    REL  = 2'd1,
    IDLE = 2'd2,
    REQ  = 2'd3
  } chan_state_e;

  // Pipeline depth on the incoming token; guarantees the dead cycle on the wires.
  localparam int DEAD_CYCLES = 1;

  function automatic int hold_width(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/bidir_chan_ctrl.sv
// Per-link direction controller: token-based ownership of a BiNoC bidirectional channel.
// Optional handover counter enabled by defining BINOC_HANDOVER_CNT_EN.
module bidir_chan_ctrl
  import binoc_pkg::*;
#(
  parameter bit INIT_OWN = 1'b0,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             local_req,
  input  logic             local_busy,
  input  logic             req_in,
  input  logic             tok_in,
  output logic             req_out,
  output logic             tok_out,
  output logic             drive_en,
  output logic             proto_err,
  output logic [CNT_W-1:0] handover_cnt
);

  localparam int                HOLD_W    = hold_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam chan_state_e       RST_STATE = INIT_OWN ? OWN : IDLE;

  chan_state_e            state;
  chan_state_e            state_nxt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [DEAD_CYCLES-1:0] tok_pipe;
  logic                   tok_seen;

  assign tok_seen = tok_pipe[DEAD_CYCLES-1];

  // Next-state decode; a token seen while owning is ignored here and flagged below.
  always_comb begin
    state_nxt = state;
    case (state)
      OWN: begin
        if (req_in && !local_busy && (!local_req || hold_cnt == HOLD_MAX)) state_nxt = REL;
        else state_nxt = OWN;
      end
      REL: state_nxt = IDLE;
      IDLE: begin
        if (tok_seen) state_nxt = OWN;
        else if (local_req) state_nxt = REQ;
        else state_nxt = IDLE;
      end
      REQ: begin
        if (tok_seen) state_nxt = OWN;
        else if (!local_req) state_nxt = IDLE;
        else state_nxt = REQ;
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  // State register with Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      drive_en <= INIT_OWN;
      req_out  <= 1'b0;
      tok_out  <= 1'b0;
    end else begin
      state    <= state_nxt;
      drive_en <= (state_nxt == OWN);
      req_out  <= (state_nxt == REQ);
      tok_out  <= (state_nxt == REL);
    end
  end

  // Hold counter: counts idle-link cycles the peer has waited while we own.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state != OWN || !req_in) begin
      hold_cnt <= '0;
    end else if (!local_busy && hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // Token delay line and sticky protocol-error flag; reset discards in-flight tokens.
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_pipe  <= '0;
      proto_err <= 1'b0;
    end else begin
      tok_pipe <= DEAD_CYCLES'({tok_pipe, tok_in});
      if (tok_seen && (state == OWN || state == REL)) proto_err <= 1'b1;
    end
  end

`ifdef BINOC_HANDOVER_CNT_EN
  logic [CNT_W-1:0] ho_cnt;

  // Saturating count of completed releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      ho_cnt <= '0;
    end else if (state == REL && ho_cnt != {CNT_W{1'b1}}) begin
      ho_cnt <= ho_cnt + CNT_W'(1);
    end
  end

  assign handover_cnt = ho_cnt;
`else
  assign handover_cnt = '0;
`endif

endmodule

// File: tb/tb_bidir_chan_ctrl.sv
// Directed bench: two cross-connected controllers (A owns after reset, B does not).
module tb_bidir_chan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_lreq = 1'b0, a_busy = 1'b0, b_lreq = 1'b0, b_busy = 1'b0;
  logic inj_a = 1'b0, inj_b = 1'b0;
  logic a_req, a_tok, a_de, a_perr;
  logic b_req, b_tok, b_de, b_perr;
  logic [15:0] a_cnt, b_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

`ifdef BINOC_HANDOVER_CNT_EN
  localparam int EXP_CNT1 = 1;
`else
  localparam int EXP_CNT1 = 0;
`endif

  always #5 clk = ~clk;

  bidir_chan_ctrl #(.INIT_OWN(1'b1), .MAX_HOLD(8), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .local_req(a_lreq), .local_busy(a_busy),
    .req_in(b_req), .tok_in(b_tok | inj_a),
    .req_out(a_req), .tok_out(a_tok), .drive_en(a_de), .proto_err(a_perr),
    .handover_cnt(a_cnt)
  );

  bidir_chan_ctrl #(.INIT_OWN(1'b0), .MAX_HOLD(8), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .local_req(b_lreq), .local_busy(b_busy),
    .req_in(a_req), .tok_in(a_tok | inj_b),
    .req_out(b_req), .tok_out(b_tok), .drive_en(b_de), .proto_err(b_perr),
    .handover_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_lreq = 1'b0; a_busy = 1'b0; b_lreq = 1'b0; b_busy = 1'b0;
    inj_a = 1'b0; inj_b = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // Both ends must never drive the shared wires in the same cycle.
  always @(negedge clk) begin
    if (!rst) begin
      n_asserts++;
      assert ((a_de & b_de) === 1'b0)
      else begin
        n_fail++;
        $error("FAIL single_owner: observed a_de=%0b b_de=%0b expected not both 1", a_de, b_de);
      end
    end
  end

  initial begin
    // 1: reset state
    do_reset();
    check("rst_a_de", 32'(a_de), 32'd1);
    check("rst_b_de", 32'(b_de), 32'd0);
    check("rst_reqs", 32'({a_req, b_req}), 32'd0);
    check("rst_toks", 32'({a_tok, b_tok}), 32'd0);
    check("rst_perr", 32'({a_perr, b_perr}), 32'd0);
    check("rst_cnt",  32'(a_cnt), 32'd0);

    // 2: basic handover A -> B with one dead cycle
    b_lreq = 1'b1;
    tick(1);
    check("ho_b_req_c1", 32'(b_req), 32'd1);
    check("ho_a_de_c1",  32'(a_de),  32'd1);
    tick(1);
    check("ho_a_tok_c2", 32'(a_tok), 32'd1);
    check("ho_a_de_c2",  32'(a_de),  32'd0);
    tick(1);
    check("ho_a_tok_c3", 32'(a_tok), 32'd0);
    check("ho_b_de_c3",  32'(b_de),  32'd0);
    tick(1);
    check("ho_b_de_c4",  32'(b_de),  32'd1);
    check("ho_b_req_c4", 32'(b_req), 32'd0);
    check("ho_a_cnt",    32'(a_cnt), 32'(EXP_CNT1));

    // 3: hold limit arbitrates when both sides want the link
    do_reset();
    a_lreq = 1'b1; b_lreq = 1'b1;
    tick(1);
    check("hold_b_req", 32'(b_req), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check($sformatf("hold_a_de_%0d", i), 32'(a_de), 32'd1);
    end
    tick(1);
    check("hold_a_de_rel",  32'(a_de),  32'd0);
    check("hold_a_tok_rel", 32'(a_tok), 32'd1);
    tick(2);
    check("hold_b_de",  32'(b_de),  32'd1);
    check("hold_a_req", 32'(a_req), 32'd1);
    check("hold_a_cnt", 32'(a_cnt), 32'(EXP_CNT1));

    // 4: busy blocks release even with the hold limit reached
    do_reset();
    a_lreq = 1'b1; b_lreq = 1'b1;
    tick(9);
    a_busy = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      check($sformatf("busy_a_de_%0d", i), 32'(a_de), 32'd1);
    end
    a_busy = 1'b0;
    tick(1);
    check("busy_a_de_rel",  32'(a_de),  32'd0);
    check("busy_a_tok_rel", 32'(a_tok), 32'd1);
    tick(2);
    check("busy_b_de", 32'(b_de), 32'd1);

    // 5: withdrawn request, late token still taken
    do_reset();
    b_lreq = 1'b1;
    tick(1);
    check("late_b_req_c1", 32'(b_req), 32'd1);
    b_lreq = 1'b0;
    tick(1);
    check("late_b_req_c2", 32'(b_req), 32'd0);
    check("late_a_tok_c2", 32'(a_tok), 32'd1);
    check("late_a_de_c2",  32'(a_de),  32'd0);
    tick(1);
    check("late_b_de_c3", 32'(b_de), 32'd0);
    tick(1);
    check("late_b_de_c4", 32'(b_de), 32'd1);
    check("late_a_de_c4", 32'(a_de), 32'd0);

    // 6: stray token into the owner, then reset mid-release
    inj_b = 1'b1;
    tick(1);
    inj_b = 1'b0;
    tick(1);
    check("perr_b_set", 32'(b_perr), 32'd1);
    check("perr_b_de",  32'(b_de),   32'd1);
    check("perr_a_clr", 32'(a_perr), 32'd0);
    tick(3);
    check("perr_b_sticky", 32'(b_perr), 32'd1);
    check("perr_b_de2",    32'(b_de),   32'd1);
    a_lreq = 1'b1;
    tick(2);
    check("mid_rel_b_tok", 32'(b_tok), 32'd1);
    rst = 1'b1;
    a_lreq = 1'b0;
    tick(1);
    check("rrst_a_de",   32'(a_de),   32'd1);
    check("rrst_b_de",   32'(b_de),   32'd0);
    check("rrst_b_perr", 32'(b_perr), 32'd0);
    check("rrst_b_tok",  32'(b_tok),  32'd0);
    check("rrst_a_req",  32'(a_req),  32'd0);
    rst = 1'b0;
    tick(3);
    check("post_a_de",   32'(a_de),   32'd1);
    check("post_b_de",   32'(b_de),   32'd0);
    check("post_a_perr", 32'(a_perr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
